// File: rtl/cpu_pkg.sv
// Shared fetch-path constants: datapath widths, opcode field position and fetch state encoding.
package cpu_pkg;

    localparam int          ADDR_W   = 16;
    localparam int          INSTR_W  = 16;
    localparam logic [3:0]  HALT_OPC = 4'hF;

    // Opcode occupies the top nibble of every instruction
    localparam int          OPC_MSB  = 15;
    localparam int          OPC_LSB  = 12;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous {pc, instr} FIFO with flush and a registered head so decode sees
// flop outputs that hold steady while it stalls.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 16,
    parameter int IW    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [AW-1:0]              push_pc,
    input  logic [IW-1:0]              push_instr,
    output logic                       valid,
    output logic [AW-1:0]              head_pc,
    output logic [IW-1:0]              head_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [AW-1:0]    r_mem_pc    [DEPTH];
    logic [IW-1:0]    r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_head_pc;
    logic [IW-1:0]    r_head_instr;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_after_pop;

    assign w_pop           = pop & (r_cnt != '0);
    assign w_push          = push & ((r_cnt != CNT_W'(DEPTH)) | w_pop);
    assign w_rd_nxt        = w_pop ? r_rd + 1'b1 : r_rd;
    assign w_cnt_after_pop = w_pop ? r_cnt - 1'b1 : r_cnt;

    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem_pc[r_wr]    <= push_pc;
            r_mem_instr[r_wr] <= push_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_head_pc    <= '0;
            r_head_instr <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_rd  <= w_rd_nxt;
            r_cnt <= w_push ? w_cnt_after_pop + 1'b1 : w_cnt_after_pop;
            if (w_push)
                r_wr <= r_wr + 1'b1;
            // An empty-after-pop queue takes its new head straight from the push data
            if (w_push && (w_cnt_after_pop == '0)) begin
                r_head_pc    <= push_pc;
                r_head_instr <= push_instr;
            end else begin
                r_head_pc    <= r_mem_pc[w_rd_nxt];
                r_head_instr <= r_mem_instr[w_rd_nxt];
            end
        end
    end

    assign valid      = (r_cnt != '0);
    assign count      = r_cnt;
    assign head_pc    = r_head_pc;
    assign head_instr = r_head_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, fetches one instruction per cycle into a small queue for decode,
// and handles redirects, decode backpressure and HALT.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_WIDTH  = ADDR_W,
    parameter int                INSTR_WIDTH = INSTR_W,
    parameter int                QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]        HALT_OPCODE = HALT_OPC
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [ADDR_WIDTH-1:0]         pc_out,
    input  logic [INSTR_WIDTH-1:0]        instr_in,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    output logic                          dec_valid,
    input  logic                          dec_ready,
    output logic [INSTR_WIDTH-1:0]        dec_instr,
    output logic [ADDR_WIDTH-1:0]         dec_pc,
    output logic                          halted,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_halted;

    logic                  w_pop;
    logic                  w_room;
    logic                  w_push;
    logic                  w_is_halt;

    assign w_pop     = dec_valid & dec_ready;
    // A full queue still accepts a fetch when its head leaves this cycle
    assign w_room    = (queue_count != CNT_W'(QUEUE_DEPTH)) | w_pop;
    assign w_push    = (r_state == FETCH) & ~redirect_valid & w_room;
    assign w_is_halt = (instr_in[OPC_MSB:OPC_LSB] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= ADDR_WIDTH'(RESET_PC);
            r_state  <= FETCH;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_state  <= FETCH;
            r_halted <= 1'b0;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
            if (w_is_halt) begin
                r_state  <= HALTED;
                r_halted <= 1'b1;
            end
        end
    end

    instr_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .AW    (ADDR_WIDTH),
        .IW    (INSTR_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .push_pc    (r_pc),
        .push_instr (instr_in),
        .valid      (dec_valid),
        .head_pc    (dec_pc),
        .head_instr (dec_instr),
        .count      (queue_count)
    );

    assign pc_out = r_pc;
    assign halted = r_halted;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives the ProgramCounter address of the combinational instruction memory (16-bit address in, 16-bit instruction out, same-cycle read) and owns the PC register.
- Buffers fetched instructions with their PCs in a small FIFO.
- Hands instructions to decode over a valid/ready handshake.
- Handles branch redirects (flush), stalls (backpressure) and a HALT opcode that stops fetching.

Parameters:
- ADDR_WIDTH, 16, PC / instruction-memory address width.
- INSTR_WIDTH, 16, instruction width.
- QUEUE_DEPTH, 2, instruction FIFO entries; power of two, minimum 2.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that stops fetching.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_out  out  ADDR_WIDTH  address to instruction memory ProgramCounter; equals the PC register.
- instr_in  in  INSTR_WIDTH  instructionOut from memory for address pc_out, same cycle.
- redirect_valid  in  1  branch/jump taken; load a new PC.
- redirect_pc  in  ADDR_WIDTH  target PC, sampled when redirect_valid=1.
- dec_valid  out  1  FIFO head is valid.
- dec_ready  in  1  decode accepts the head this cycle.
- dec_instr  out  INSTR_WIDTH  FIFO head instruction.
- dec_pc  out  ADDR_WIDTH  PC of the FIFO head instruction.
- halted  out  1  a HALT instruction has been fetched; fetching is stopped.
- queue_count  out  clog2(QUEUE_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, when reset=1 at an edge:
  - PC=RESET_PC, FIFO emptied (count=0), halted=0.
  - dec_valid=0, dec_instr=0, dec_pc=0.
  - Reset has priority over everything, including mid-redirect or a full FIFO.
- States: FETCH, HALTED.
  - FETCH -> HALTED when a pushed instr has instr[15:12]==HALT_OPCODE.
  - HALTED -> FETCH only on redirect_valid.
  - halted=1 exactly in HALTED.
- pop = dec_valid & dec_ready.
- push, in FETCH with no redirect: push = (count<QUEUE_DEPTH) | pop.
  - A full FIFO accepts a push in the same cycle it pops.
- On push:
  - Write {pc_out, instr_in} at the tail; PC <= PC+1.
  - PC wraps modulo 2^ADDR_WIDTH, so 16'hFFFF+1 = 16'h0000.
- No push (full without pop, or HALTED): PC holds.
- Redirect, when redirect_valid=1 (not reset):
  - PC <= redirect_pc; FIFO flushed (count=0); state -> FETCH.
  - No push that cycle; a pop in the same cycle is still a valid handoff of the current head.
  - First fetch from the target happens next cycle.
  - A redirect while HALTED resumes fetching.
- Latency:
  - An instruction at pc_out enters the FIFO at edge N.
  - dec_valid is asserted with it from the cycle after edge N.
  - Minimum fetch-to-decode latency is 1 cycle.
  - Steady state is 1 instr/cycle with dec_ready held high.
- Ordering and outputs:
  - FIFO ordering is strict: dec_pc sequence equals fetch order.
  - dec_instr/dec_pc are registered FIFO head outputs, stable while dec_valid=1 and dec_ready=0.
  - dec_valid = (count != 0).
- The HALT instruction itself is enqueued and delivered to decode; no instruction after it is fetched.
- Count update: count' = count + push - pop; it can never exceed QUEUE_DEPTH or go below 0.

Decomposition:
- Shared package cpu_pkg: ADDR_WIDTH/INSTR_WIDTH constants, HALT_OPCODE, opcode field slice positions [15:12], fetch state enum {FETCH, HALTED}.
- One sub-module is natural: instr_fifo.
  - Parameterised synchronous FIFO of {pc, instr} with push/pop/flush, count, and registered head output.
- fetch_sequencer holds the PC register, the state machine and the push/redirect logic.

Test Plan:
1. Reset, memory holding instr = 16'h1000 + address, dec_ready=1:
   - pc_out steps 0,1,2,...
   - dec_pc=0 with dec_instr=16'h1000 on the first valid cycle, then one per cycle in order.
   - queue_count stays at 1.
2. dec_ready=0 from reset:
   - FIFO fills to 2 (dec_pc 0 and 1) and pc_out holds at 2.
   - Raise dec_ready: PC 2 is fetched in the same cycle PC 0 pops; no entry is lost or duplicated.
3. Redirect:
   - Assert redirect_valid with redirect_pc=16'h0010 while the FIFO holds 2 entries: queue_count=0 next cycle, pc_out=16'h0010.
   - The next delivered dec_pc is 16'h0010 with matching instruction.
4. HALT:
   - Memory address 5 holds 16'hF000: the instruction at PC 5 is delivered, halted=1, pc_out stays at 6, no further dec_valid.
   - redirect_pc=16'h0000 clears halted and restarts fetching at 0.
5. Wrap:
   - redirect_pc=16'hFFFE: delivered dec_pc sequence is FFFE, FFFF, 0000, 0001.
6. Mid-operation reset:
   - Assert reset with the FIFO full and state HALTED: next cycle pc_out=RESET_PC, queue_count=0, dec_valid=0, halted=0, and fetching restarts.
